// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, widths and ALU op codes.
package alu_arb_pkg;

    localparam int OPW = 4;
    localparam int DW  = 32;
    localparam int SHW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Branch ops also produce a - b on the result bus.
    localparam logic [OPW-1:0] OP_ADD   = 4'd0;
    localparam logic [OPW-1:0] OP_SUB   = 4'd1;
    localparam logic [OPW-1:0] OP_AND   = 4'd2;
    localparam logic [OPW-1:0] OP_OR    = 4'd3;
    localparam logic [OPW-1:0] OP_XOR   = 4'd4;
    localparam logic [OPW-1:0] OP_NOR   = 4'd5;
    localparam logic [OPW-1:0] OP_SLT   = 4'd6;
    localparam logic [OPW-1:0] OP_SLTU  = 4'd7;
    localparam logic [OPW-1:0] OP_SLL   = 4'd8;
    localparam logic [OPW-1:0] OP_SRL   = 4'd9;
    localparam logic [OPW-1:0] OP_SRA   = 4'd10;
    localparam logic [OPW-1:0] OP_BEQ   = 4'd11;
    localparam logic [OPW-1:0] OP_BNE   = 4'd12;
    localparam logic [OPW-1:0] OP_BLT   = 4'd13;
    localparam logic [OPW-1:0] OP_BGE   = 4'd14;
    localparam logic [OPW-1:0] OP_PASSB = 4'd15;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU with a branch-condition output.
module alu_arbiter_alu
    import alu_arb_pkg::*;
(
    input  logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  read_reg_1,
    input  logic [DW-1:0]  read_data_2,
    output logic [DW-1:0]  alu_output,
    output logic           branch_output
);

    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb;
    logic [SHW-1:0]       shamt;

    assign sa    = $signed(read_reg_1);
    assign sb    = $signed(read_data_2);
    assign shamt = read_data_2[SHW-1:0];

    always_comb begin
        alu_output    = '0;
        branch_output = 1'b0;
        case (alu_op)
            OP_ADD:   alu_output = read_reg_1 + read_data_2;
            OP_SUB:   alu_output = read_reg_1 - read_data_2;
            OP_AND:   alu_output = read_reg_1 & read_data_2;
            OP_OR:    alu_output = read_reg_1 | read_data_2;
            OP_XOR:   alu_output = read_reg_1 ^ read_data_2;
            OP_NOR:   alu_output = ~(read_reg_1 | read_data_2);
            OP_SLT:   alu_output = {{(DW-1){1'b0}}, (sa < sb)};
            OP_SLTU:  alu_output = {{(DW-1){1'b0}}, (read_reg_1 < read_data_2)};
            OP_SLL:   alu_output = read_reg_1 << shamt;
            OP_SRL:   alu_output = read_reg_1 >> shamt;
            OP_SRA:   alu_output = $unsigned(sa >>> shamt);
            OP_BEQ: begin
                alu_output    = read_reg_1 - read_data_2;
                branch_output = (read_reg_1 == read_data_2);
            end
            OP_BNE: begin
                alu_output    = read_reg_1 - read_data_2;
                branch_output = (read_reg_1 != read_data_2);
            end
            OP_BLT: begin
                alu_output    = read_reg_1 - read_data_2;
                branch_output = (sa < sb);
            end
            OP_BGE: begin
                alu_output    = read_reg_1 - read_data_2;
                branch_output = (sa >= sb);
            end
            OP_PASSB: alu_output = read_data_2;
            default: begin
                alu_output    = '0;
                branch_output = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, one operation in flight at a time.
//   state | meaning
//   IDLE  | waiting for a request; grants one and captures its operands
//   EXEC  | ALU evaluates captured operands; result latched at end of cycle
//   RESP  | response held valid until rsp_ready
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][OPW-1:0]  req_op,
    input  logic [NREQ-1:0][DW-1:0]   req_a,
    input  logic [NREQ-1:0][DW-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DW-1:0]             rsp_result,
    output logic                      rsp_branch,
    output logic [IDW-1:0]            rsp_id,
    output logic                      busy
);

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           accept;

    logic [OPW-1:0] op_q;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic [IDW-1:0] id_q;

    logic [DW-1:0]  alu_output;
    logic           branch_output;

    // Search begins one past the last granted requester and wraps.
    always_comb begin
        logic [IDW-1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(last_grant) + 1 + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = (state == IDLE) && grant_found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_result <= '0;
            rsp_branch <= 1'b0;
            rsp_id     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= req_op[grant_idx];
                a_q        <= req_a[grant_idx];
                b_q        <= req_b[grant_idx];
                id_q       <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_result <= alu_output;
                rsp_branch <= branch_output;
                rsp_id     <= id_q;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    alu_arbiter_alu u_alu (
        .alu_op        (op_q),
        .read_reg_1    (a_q),
        .read_data_2   (b_q),
        .alu_output    (alu_output),
        .branch_output (branch_output)
    );

endmodule
